arbitro_mux4: RTL and testbench
===============================

# arbitro_mux4

Round-robin arbiter that shares one 4-input multiplexer among four requesters. It owns the mux select line and grants exclusive use to one requester at a time, with a bounded tenure so no requester can starve the others. It sits between the four source controllers and the `mux4_1` datapath instance, driving that instance's `sel` directly.

## Interface
- `MAX_CYCLES`, default 8: maximum consecutive cycles one grant may be held; legal range 1..255. The tenure counter width is `$clog2(MAX_CYCLES+1)`.
- `clock`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  4  request per source; bit i is requester i.
- `release`  in  1  the current owner has finished; sampled only in GRANT.
- `grant`  out  4  one-hot grant, or all zeros when there is no owner.
- `sel`  out  2  index of the owner; connects to the mux `sel`.
- `busy`  out  1  high while a grant is active.

## Operation
- All outputs are registered.
- There are three states: IDLE, GRANT and GAP.
- Priority pointer `last` (2 bits) holds the index of the most recent owner. Search order starts at `last+1` and wraps mod 4: 3 wraps to 0.
- **Reset:**
  - state=IDLE, `last`=3, so requester 0 has top priority first.
  - `grant`=0000, `sel`=00, `busy`=0, tenure counter=0.
- **IDLE:**
  - If `req`≠0, pick the first set bit in search order and call it w.
  - Next cycle: state=GRANT, `grant`=1<<w, `sel`=w, `busy`=1, `last`=w, counter=1.
  - If `req`=0, stay in IDLE.
- **GRANT:** the counter counts grant cycles, including the first. The tenure ends when any of these holds:
  - `release`=1;
  - `req[sel]`=0 (the requester withdrew);
  - counter==`MAX_CYCLES`.
  - Otherwise the counter increments and `grant`/`sel` hold.
- **End of tenure:** the next state is GAP, with `grant`=0000, `busy`=0 and counter=0. `sel` holds its last value, so the mux output does not glitch.
- **GAP:** one dead cycle for the owner to disconnect, then IDLE unconditionally. `req` is ignored in GAP.
- **Simultaneous events:**
  - `release` together with timeout, or together with `req` drop, ends the tenure once; the result is identical to GAP.
  - `release` outside GRANT is ignored.
- **Fairness:**
  - With all four requesting continuously, grants rotate 0,1,2,3,0,…
  - A requester that was just served is considered last.
  - A requester that raises `req` during another's tenure is served within at most 3 tenures.
- **Reset mid-operation:** it wins over every other input in any state. The next cycle shows the reset values above, and any current grant is dropped.
- **Invariants:**
  - `grant` is always one-hot or zero.
  - `busy` == |`grant`.
  - `grant`≠0 implies `grant`[`sel`]=1.

## Timing
- Arbitration latency: `req` sampled in IDLE at edge N gives `grant`/`busy` valid after edge N+1, i.e. one cycle.
- Tenure length: 1 to `MAX_CYCLES` cycles of `grant` high.
- Turnaround: after a tenure ends there are at least 2 cycles with `grant`=0, one in GAP and one in IDLE, before the next grant. If `release` is sampled at edge k, `grant` is low after edge k and the earliest next grant is after edge k+2.
- Throughput with continuous requests: `MAX_CYCLES` of every `MAX_CYCLES`+2 cycles.
- There are no combinational paths from inputs to outputs.

## Test plan
- **Reset values:** assert `reset` for 2 cycles with `req`=1111 → `grant`=0000, `sel`=00, `busy`=0 throughout. Deassert → after 1 cycle in IDLE, `grant`=0001, `sel`=00.
- **Single requester:** `req`=0100, `release` pulsed on the 3rd grant cycle → `grant`=0100 and `sel`=10 for exactly 3 cycles, then 0000 in GAP with `sel` still 10. Keeping `req`=0100 re-grants 2 cycles after the release edge.
- **Rotation and timeout:** `MAX_CYCLES`=4, `req`=1111 constant, `release`=0 → grants in order 0001,0010,0100,1000,0001. Each lasts 4 cycles and is separated by 2 zero cycles.
- **Withdrawal and pointer:** owner 1 drops `req[1]` on its 2nd cycle while `req`=0101 → tenure ends after 2 cycles. The next grant goes to requester 2 (0100), not 0, because the search starts after `last`=1.
- **Simultaneous end conditions:** `MAX_CYCLES`=4, `release`=1 on the 4th cycle with `req[sel]` dropping in the same cycle → a single transition to GAP. `grant` stays one-hot or zero and `busy` matches it every cycle.
- **Reset mid-grant:** assert `reset` during the 2nd cycle of grant 0010 → next cycle `grant`=0000, `sel`=00, `busy`=0. After release with `req`=1111, the first grant is 0001.

Source files
------------

// File: rtl/arbitro_mux4.sv
// Round-robin owner of a shared 4:1 mux select, with bounded grant tenure.
// Latency: request sampled in IDLE -> grant/sel/busy registered one cycle later.
// Backpressure: none; a tenure ends on release, request withdrawal or timeout, then two dead cycles.
module arbitro_mux4 #(
  parameter int unsigned MAX_CYCLES = 8
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [3:0] i_req,
  input  logic       i_release,
  output logic [3:0] o_grant,
  output logic [1:0] o_sel,
  output logic       o_busy
);

  // Tenure counter must be able to hold MAX_CYCLES itself.
  localparam int unsigned   CW      = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Registered state and outputs.
  state_t        r_state;
  logic [1:0]    r_last;
  logic [1:0]    r_sel;
  logic [3:0]    r_grant;
  logic          r_busy;
  logic [CW-1:0] r_cnt;

  // Combinational next values.
  state_t        w_state_nxt;
  logic [1:0]    w_last_nxt;
  logic [1:0]    w_sel_nxt;
  logic [3:0]    w_grant_nxt;
  logic          w_busy_nxt;
  logic [CW-1:0] w_cnt_nxt;

  // Arbitration helpers.
  logic [1:0]    w_idx;
  logic [1:0]    w_win;
  logic          w_win_vld;
  logic          w_end;

  // Winner search: scan last+1, last+2, ... wrapping mod 4, so the previous owner is looked at last.
  always_comb begin
    w_idx     = 2'd0;
    w_win     = 2'd0;
    w_win_vld = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last + 2'(k);
      if (!w_win_vld && i_req[w_idx]) begin
        w_win     = w_idx;
        w_win_vld = 1'b1;
      end
    end
  end

  // Any one of the three end conditions closes the tenure; overlapping ones still close it once.
  always_comb begin
    w_end = i_release | ~i_req[r_sel] | (r_cnt == CNT_MAX);
  end

  // State and output registers; reset overrides every other input in every state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_last  <= 2'd3;
      r_sel   <= 2'd0;
      r_grant <= 4'b0000;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_sel   <= w_sel_nxt;
      r_grant <= w_grant_nxt;
      r_busy  <= w_busy_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: IDLE -> GRANT on any request, GRANT -> GAP at end of tenure, GAP -> IDLE always.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_end) begin
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Next-output logic; sel is never cleared outside reset so the mux output stays steady in the dead cycles.
  always_comb begin
    w_last_nxt  = r_last;
    w_sel_nxt   = r_sel;
    w_grant_nxt = r_grant;
    w_busy_nxt  = r_busy;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_grant_nxt = 4'b0001 << w_win;
          w_sel_nxt   = w_win;
          w_last_nxt  = w_win;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_grant_nxt = 4'b0000;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      S_GRANT: begin
        if (w_end) begin
          w_grant_nxt = 4'b0000;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      S_GAP: begin
        w_grant_nxt = 4'b0000;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_grant_nxt = 4'b0000;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_grant = r_grant;
  assign o_sel   = r_sel;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_arbitro_mux4.sv
// Bench for arbitro_mux4 with a tenure limit of 4 cycles.
// Hand-derived vector table, a rotation/timeout sequence, then random traffic against a reference model.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_arbitro_mux4;

  localparam int MAXC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       rel;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: phase 0 = idle, 1 = owner holds the mux, 2 = dead cycle.
  int m_phase = 0;
  int m_owner = 0;
  int m_last  = 3;
  int m_cnt   = 0;
  int m_sel   = 0;

  always #5 clk = ~clk;

  arbitro_mux4 #(.MAX_CYCLES(MAXC)) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_req     (req),
    .i_release (rel),
    .o_grant   (grant),
    .o_sel     (sel),
    .o_busy    (busy)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rel;
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
  } vec_t;

  vec_t tbl [30];

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got grant=%b sel=%0d busy=%b, want grant=%b sel=%0d busy=%b",
               name, act[6:3], act[2:1], act[0], exp[6:3], exp[2:1], exp[0]);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b (grant=%b sel=%0d busy=%b)", name, act, exp, grant, sel, busy);
    end
  endtask

  // One clock of the arbitration rules, stated directly as the model sees them.
  task automatic model_step(input logic r, input logic [3:0] q, input logic l);
    if (r) begin
      m_phase = 0;
      m_last  = 3;
      m_sel   = 0;
      m_cnt   = 0;
    end else if (m_phase == 0) begin
      if (q != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (m_last + k) % 4;
          if (m_phase == 0 && q[c]) begin
            m_owner = c;
            m_sel   = c;
            m_last  = c;
            m_cnt   = 1;
            m_phase = 1;
          end
        end
      end
    end else if (m_phase == 1) begin
      if (l || !q[m_owner] || m_cnt == MAXC) begin
        m_phase = 2;
        m_cnt   = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  function automatic logic [6:0] model_out();
    logic [3:0] g;
    g = 4'b0000;
    if (m_phase == 1) g[m_owner] = 1'b1;
    return {g, 2'(m_sel), (m_phase == 1)};
  endfunction

  // Apply inputs for one cycle, advance the model, then check model agreement and invariants.
  task automatic tick(input logic r, input logic [3:0] q, input logic l, input string tag);
    rst = r;
    req = q;
    rel = l;
    @(posedge clk);
    model_step(r, q, l);
    #1;
    check({tag, ":model"}, {grant, sel, busy}, model_out());
    chk1({tag, ":onehot0"}, $onehot0(grant), 1'b1);
    chk1({tag, ":busy_eq_or"}, busy, |grant);
    chk1({tag, ":grant_sel"}, (grant == 4'b0000) || grant[sel], 1'b1);
  endtask

  initial begin
    logic [3:0] rq;
    logic [3:0] eg;
    int n, p;

    // rst, req, rel -> grant, sel, busy after the edge
    tbl[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0};  // reset held
    tbl[1]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};  // requester 0 first
    tbl[3]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[4]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};  // single requester
    tbl[5]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
    tbl[6]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
    tbl[7]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0};  // release -> GAP, sel holds
    tbl[8]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 2'd2, 1'b0};  // IDLE
    tbl[9]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};  // re-grant at k+2
    tbl[10] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
    tbl[11] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[12] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1};  // owner 1
    tbl[13] = '{1'b0, 4'b0111, 1'b0, 4'b0010, 2'd1, 1'b1};
    tbl[14] = '{1'b0, 4'b0101, 1'b0, 4'b0000, 2'd1, 1'b0};  // withdrawal ends tenure
    tbl[15] = '{1'b0, 4'b0101, 1'b0, 4'b0000, 2'd1, 1'b0};
    tbl[16] = '{1'b0, 4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1};  // 2 beats 0 after last=1
    tbl[17] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[18] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1};  // owner 3, full tenure
    tbl[19] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1};
    tbl[20] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1};
    tbl[21] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1};  // 4th cycle shown
    tbl[22] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0};  // release+drop+timeout together
    tbl[23] = '{1'b0, 4'b1000, 1'b0, 4'b0000, 2'd3, 1'b0};
    tbl[24] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1};
    tbl[25] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};  // reset straight out of GRANT
    tbl[26] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1};
    tbl[27] = '{1'b0, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1};  // 2nd cycle of grant 0010
    tbl[28] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0};  // reset mid-grant
    tbl[29] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};  // restarts at requester 0

    rst = 1'b1;
    req = 4'b0000;
    rel = 1'b0;

    for (int i = 0; i < 30; i++) begin
      tick(tbl[i].rst, tbl[i].req, tbl[i].rel, $sformatf("tbl%0d", i));
      check($sformatf("tbl[%0d]", i), {grant, sel, busy}, {tbl[i].g, tbl[i].s, tbl[i].b});
    end

    // Rotation with timeout: owner 0 is on its first cycle; period is 4 grant + 2 dead cycles.
    for (int j = 1; j < 30; j++) begin
      tick(1'b0, 4'b1111, 1'b0, $sformatf("rot%0d", j));
      n  = j / 6;
      p  = j % 6;
      eg = 4'b0000;
      if (p < 4) eg[n % 4] = 1'b1;
      check($sformatf("rotation[%0d]", j), {grant, sel, busy}, {eg, 2'(n % 4), (p < 4)});
    end

    // Random traffic: requests mostly persist, releases and resets sprinkled in.
    rq = 4'b1111;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      tick(($urandom_range(0, 99) == 0), rq, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
